// File: rtl/qdr_init_pkg.sv
// Shared types, default widths and the width helper for the QDR fabric initiator.
package qdr_init_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam int DEF_ADDR_WIDTH      = 32;
  localparam int DEF_DATA_WIDTH      = 72;
  localparam int DEF_BE_WIDTH        = 8;
  localparam int DEF_MAX_OUTSTANDING = 16;
  localparam int DEF_TIMEOUT_CYCLES  = 1024;

  // Bits needed to encode values 0 .. value-1.
  function automatic int clog2(input int value);
    int res;
    int v;
    res = 0;
    v   = value - 1;
    while (v > 0) begin
      res = res + 1;
      v   = v >> 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/qdr_init_rd_tracker.sv
// Read-in-flight counter with sticky unexpected-data flag.
// Optional read watchdog is built only when QDR_INIT_RD_TIMEOUT_EN is defined.
module qdr_init_rd_tracker
  import qdr_init_pkg::*;
#(
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   rd_ack,
  input  logic                                   dvld,
  output logic [clog2(MAX_OUTSTANDING+1)-1:0]    outstanding,
  output logic                                   err_unexp,
  output logic                                   err_timeout
);

  localparam int CW = clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] CAP = CW'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("qdr_init_rd_tracker: MAX_OUTSTANDING must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic [CW-1:0] cnt;
  logic          wd_fire;

  assign outstanding = cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (dvld && cnt == '0)
        err_unexp <= 1'b1;
      // Watchdog expiry abandons every read still in flight.
      if (wd_fire)
        cnt <= '0;
      else if (rd_ack && !dvld) begin
        if (cnt != CAP)
          cnt <= cnt + CW'(1);
      end else if (dvld && !rd_ack) begin
        if (cnt != '0)
          cnt <= cnt - CW'(1);
      end
    end
  end

`ifdef QDR_INIT_RD_TIMEOUT_EN
  localparam int TW = clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] WD_LOAD = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] wd_cnt;

  // Down-counter reloads whenever the pipe is empty or data returns.
  assign wd_fire = (cnt != '0) && (wd_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt      <= WD_LOAD;
      err_timeout <= 1'b0;
    end else begin
      if (cnt == '0 || dvld)
        wd_cnt <= WD_LOAD;
      else if (wd_cnt != '0)
        wd_cnt <= wd_cnt - TW'(1);
      if (wd_fire)
        err_timeout <= 1'b1;
    end
  end
`else
  assign wd_fire     = 1'b0;
  assign err_timeout = 1'b0;
`endif

endmodule

// File: rtl/qdr_fabric_initiator.sv
// Single-request-at-a-time command issuer towards the QDR sniffer port with read tracking.
// Read watchdog enabled by defining QDR_INIT_RD_TIMEOUT_EN.
module qdr_fabric_initiator
  import qdr_init_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int BE_WIDTH        = DEF_BE_WIDTH,
  parameter int MAX_OUTSTANDING = DEF_MAX_OUTSTANDING,
  parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
  input  logic                                qdr_clk,
  input  logic                                qdr_rst,
  input  logic                                phy_rdy,
  input  logic                                cmd_valid,
  output logic                                cmd_ready,
  input  logic                                cmd_rnw,
  input  logic [ADDR_WIDTH-1:0]               cmd_addr,
  input  logic [DATA_WIDTH-1:0]               cmd_data,
  input  logic [BE_WIDTH-1:0]                 cmd_be,
  output logic [ADDR_WIDTH-1:0]               slave_addr,
  output logic                                slave_wr_strb,
  output logic [DATA_WIDTH-1:0]               slave_wr_data,
  output logic [BE_WIDTH-1:0]                 slave_wr_be,
  output logic                                slave_rd_strb,
  input  logic                                slave_ack,
  input  logic [DATA_WIDTH-1:0]               slave_rd_data,
  input  logic                                slave_rd_dvld,
  output logic                                rsp_valid,
  output logic [DATA_WIDTH-1:0]               rsp_data,
  output logic [clog2(MAX_OUTSTANDING+1)-1:0] outstanding,
  output logic                                err_unexp,
  output logic                                err_timeout
);

  localparam int OW = clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW:0] MAX_C = (OW+1)'(MAX_OUTSTANDING);

  state_e          state;
  state_e          state_nxt;
  logic            rnw_q;
  logic            accept;
  logic            rd_ack;
  logic [OW:0]     inflight;

  // A read being acked this cycle already occupies a slot before the counter shows it.
  assign rd_ack   = (state == ST_ISSUE) && rnw_q && slave_ack;
  assign inflight = {1'b0, outstanding} + {{OW{1'b0}}, rd_ack};
  assign accept   = cmd_valid && cmd_ready;

  always_comb begin
    state_nxt     = state;
    slave_wr_strb = 1'b0;
    slave_rd_strb = 1'b0;
    cmd_ready     = !qdr_rst && phy_rdy
                    && (state == ST_IDLE || slave_ack)
                    && (inflight < MAX_C);
    case (state)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready)
          state_nxt = ST_ISSUE;
      end
      ST_ISSUE: begin
        slave_wr_strb = !rnw_q;
        slave_rd_strb = rnw_q;
        if (slave_ack && !(cmd_valid && cmd_ready))
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge qdr_clk or posedge qdr_rst) begin
    if (qdr_rst)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge qdr_clk or posedge qdr_rst) begin
    if (qdr_rst) begin
      rnw_q         <= 1'b0;
      slave_addr    <= '0;
      slave_wr_data <= '0;
      slave_wr_be   <= '0;
    end else if (accept) begin
      rnw_q         <= cmd_rnw;
      slave_addr    <= cmd_addr;
      slave_wr_data <= cmd_data;
      slave_wr_be   <= cmd_be;
    end
  end

  always_ff @(posedge qdr_clk or posedge qdr_rst) begin
    if (qdr_rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      rsp_valid <= slave_rd_dvld;
      if (slave_rd_dvld)
        rsp_data <= slave_rd_data;
    end
  end

  qdr_init_rd_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING),
    .TIMEOUT_CYCLES  (TIMEOUT_CYCLES)
  ) u_rd_tracker (
    .clk         (qdr_clk),
    .rst         (qdr_rst),
    .rd_ack      (rd_ack),
    .dvld        (slave_rd_dvld),
    .outstanding (outstanding),
    .err_unexp   (err_unexp),
    .err_timeout (err_timeout)
  );

endmodule

// File: doc/qdr_fabric_initiator.md
QDR_FABRIC_INITIATOR -- requirements
Module: qdr_fabric_initiator

Interface
REQ-001 The block SHALL have these parameters: ADDR_WIDTH (32, slave_addr width); DATA_WIDTH (72, data width); BE_WIDTH (8, byte-enable width); MAX_OUTSTANDING (16, read-in-flight cap, >=2); TIMEOUT_CYCLES (1024, read watchdog limit).
REQ-002 The block SHALL have a single clock, qdr_clk; reset is asynchronous and active-high, qdr_rst.
REQ-003 The block SHALL have these ports (name, direction, width, meaning):
- qdr_clk  in  1  clock.
- qdr_rst  in  1  async active-high reset.
- phy_rdy  in  1  QDR calibration done.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted this cycle.
- cmd_rnw  in  1  1 = read, 0 = write.
- cmd_addr  in  ADDR_WIDTH  word address.
- cmd_data  in  DATA_WIDTH  write data.
- cmd_be  in  BE_WIDTH  write byte enables.
- slave_addr  out  ADDR_WIDTH  address to sniffer.
- slave_wr_strb  out  1  write request.
- slave_wr_data  out  DATA_WIDTH  write data.
- slave_wr_be  out  BE_WIDTH  write byte enables.
- slave_rd_strb  out  1  read request.
- slave_ack  in  1  request accepted.
- slave_rd_data  in  DATA_WIDTH  read data.
- slave_rd_dvld  in  1  read data valid.
- rsp_valid  out  1  read response valid, single cycle, no backpressure.
- rsp_data  out  DATA_WIDTH  read response.
- outstanding  out  clog2(MAX_OUTSTANDING+1)  reads in flight.
- err_unexp  out  1  sticky: dvld seen with outstanding==0.
- err_timeout  out  1  sticky: read watchdog fired (macro only; tied 0 otherwise).

Function
REQ-004 The block SHALL implement two states: IDLE (no request driven) and ISSUE (exactly one strobe held).
REQ-005 cmd_ready SHALL equal phy_rdy AND (state==IDLE OR slave_ack) AND (outstanding + pending_read_ack) < MAX_OUTSTANDING, where pending_read_ack is 1 when ISSUE holds a read and slave_ack is high.
REQ-006 On cmd_valid AND cmd_ready, fields SHALL be registered; the strobe for cmd_rnw SHALL assert on the next cycle and the state SHALL be ISSUE.
REQ-007 In ISSUE, strobe, address, data and be SHALL be held stable until slave_ack is high; the request SHALL complete in that cycle.
REQ-008 On ack with no new command accepted, the state SHALL return to IDLE and both strobes SHALL deassert next cycle; ack plus acceptance SHALL issue back-to-back (one request per cycle maximum).
REQ-009 slave_wr_strb and slave_rd_strb SHALL never both be high.
REQ-010 outstanding SHALL increment on read ack, decrement on slave_rd_dvld, and stay unchanged when both occur in the same cycle; it SHALL never wrap.
REQ-011 A dvld with outstanding==0 SHALL leave the count at 0, set err_unexp, and still forward the data.
REQ-012 rsp_valid/rsp_data SHALL be slave_rd_dvld/slave_rd_data registered once (1-cycle latency); rsp_data SHALL hold its value when rsp_valid is low.
REQ-013 If phy_rdy deasserts during ISSUE, the held request SHALL continue until ack, and no new command SHALL be accepted.

Reset
REQ-014 On qdr_rst: state=IDLE; strobes, cmd_ready, rsp_valid, outstanding, err_unexp and err_timeout SHALL be 0; addr, data, be and rsp_data SHALL be 0. In-flight requests SHALL be dropped.

Configuration
REQ-015 With QDR_INIT_RD_TIMEOUT_EN defined, a counter SHALL run while outstanding>0, reset on every dvld, and clear when outstanding==0; reaching TIMEOUT_CYCLES SHALL set err_timeout and force outstanding to 0.
REQ-016 Without QDR_INIT_RD_TIMEOUT_EN, no counter SHALL exist and err_timeout SHALL be constant 0.

Structure
REQ-017 Package qdr_init_pkg SHALL hold the state enum, default widths and the clog2 helper.
REQ-018 The outstanding/watchdog tracker SHALL be sub-module qdr_init_rd_tracker; issue FSM in the top.

Verification
REQ-019 Write: phy_rdy=1, cmd write addr 0x10, data 0xA5…, be 0xFF; ack after 3 cycles -> slave_wr_strb high 3 cycles with fields stable, then IDLE.
REQ-020 Back-to-back: 4 reads with slave_ack tied 1 -> 4 consecutive rd_strb cycles, outstanding=4; 4 dvld -> 4 rsp_valid each 1 cycle late, outstanding=0.
REQ-021 Cap: MAX_OUTSTANDING=16 reads, no dvld -> cmd_ready low at 16; one dvld -> ready rises next cycle.
REQ-022 Simultaneous read ack and dvld at outstanding=3 -> stays 3; dvld at 0 -> err_unexp=1, rsp_valid pulses.
REQ-023 With macro and TIMEOUT_CYCLES=8: 1 read, no dvld -> err_timeout at cycle 8, outstanding=0; without macro -> err_timeout stays 0.
REQ-024 Reset asserted during ISSUE with outstanding=5 -> all outputs 0 immediately (asynchronous).
